// File: rtl/reg_loader_pkg.sv
// Shared types and constants for the register-bank loader/dumper.
// Holds the FSM state enum, command bytes and index width.
package reg_loader_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_COUNT,
    S_LDATA,
    S_WRITE,
    S_DREAD,
    S_DSEND
  } state_t;

  // States in which the loader consumes host bytes.
  function automatic logic takes_input(state_t s);
    return s inside {S_IDLE, S_START, S_COUNT, S_LDATA};
  endfunction

endpackage

// File: rtl/reg_loader_byte_word_shifter.sv
// 4-byte shift register with a 2-bit byte counter.
// Ports: clr (zero counter+word), load/word_in (parallel load),
//   shift_in/din (append byte at LSB), shift_out (drop MSB byte),
//   word, msb (word[31:24]), cnt (bytes shifted since clr/load).
module byte_word_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        load,
  input  logic [31:0] word_in,
  input  logic        shift_in,
  input  logic [7:0]  din,
  input  logic        shift_out,
  output logic [31:0] word,
  output logic [7:0]  msb,
  output logic [1:0]  cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      cnt  <= '0;
    end else begin
      unique case (1'b1)
        clr: begin
          word <= '0;
          cnt  <= '0;
        end
        load: begin
          word <= word_in;
          cnt  <= '0;
        end
        shift_in: begin
          word <= {word[23:0], din};
          cnt  <= cnt + 2'd1;
        end
        shift_out: begin
          word <= {word[23:0], 8'h00};
          cnt  <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign msb = word[31:24];

endmodule

// File: rtl/reg_loader.sv
// Host byte-stream loader/dumper for the register bank.
// Ports: in_* (host bytes, valid/ready), out_* (dump bytes,
//   valid/ready), WriteReg/WriteData/Regwrite (bank write port),
//   ReadReg/ReadData (bank read port), cpu_hold, err_cmd.
// Dump path compiled in only when REG_LOADER_DUMP_EN is defined.
module reg_loader
  import reg_loader_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           in_byte,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [7:0]           out_byte,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_IDX_W-1:0] WriteReg,
  output logic [31:0]          WriteData,
  output logic                 Regwrite,
  output logic [REG_IDX_W-1:0] ReadReg,
  input  logic [31:0]          ReadData,
  output logic                 cpu_hold,
  output logic                 err_cmd
);

`ifdef REG_LOADER_DUMP_EN
  localparam bit DUMP_EN = 1'b1;
`else
  localparam bit DUMP_EN = 1'b0;
`endif

  state_t               state;
  logic [REG_IDX_W-1:0] idx;
  logic [REG_IDX_W-1:0] idx_inc;
  logic [5:0]           n;
  logic                 dump_mode;
  logic                 ov_q;

  logic [31:0] sh_word;
  logic [7:0]  sh_msb;
  logic [1:0]  sh_cnt;
  logic        sh_clr;
  logic        sh_load;
  logic        sh_in;
  logic        sh_out;

  logic in_fire;
  logic out_fire;
  logic is_dump_cmd;

  assign in_ready    = takes_input(state);
  assign cpu_hold    = (state != S_IDLE);
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = ov_q & out_ready;
  assign is_dump_cmd = DUMP_EN && (in_byte == CMD_DUMP);

  assign idx_inc = (idx == REG_IDX_W'(NREGS - 1)) ?
                   '0 : idx + 1'b1;

  assign sh_clr  = (state == S_COUNT);
  assign sh_load = (state == S_DREAD);
  assign sh_in   = (state == S_LDATA) & in_fire;
  assign sh_out  = (state == S_DSEND) & out_fire;

  byte_word_shifter u_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (sh_clr),
    .load      (sh_load),
    .word_in   (ReadData),
    .shift_in  (sh_in),
    .din       (in_byte),
    .shift_out (sh_out),
    .word      (sh_word),
    .msb       (sh_msb),
    .cnt       (sh_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      n         <= '0;
      dump_mode <= 1'b0;
      ov_q      <= 1'b0;
      Regwrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      err_cmd   <= 1'b0;
    end else begin
      Regwrite <= 1'b0;
      err_cmd  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_fire) begin
            unique case (1'b1)
              (in_byte == CMD_LOAD): begin
                dump_mode <= 1'b0;
                state     <= S_START;
              end
              is_dump_cmd: begin
                dump_mode <= 1'b1;
                state     <= S_START;
              end
              default: err_cmd <= 1'b1;
            endcase
          end
        end
        S_START: begin
          if (in_fire) begin
            idx   <= REG_IDX_W'(int'(in_byte[4:0]) % NREGS);
            state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (in_fire) begin
            n     <= {1'b0, in_byte[4:0]} + 6'd1;
            state <= dump_mode ? S_DREAD : S_LDATA;
          end
        end
        S_LDATA: begin
          // Word is complete on this byte; the shifter
          // has not absorbed it yet, so splice it here.
          if (in_fire && sh_cnt == 2'd3) begin
            Regwrite  <= 1'b1;
            WriteReg  <= idx;
            WriteData <= {sh_word[23:0], in_byte};
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          idx   <= idx_inc;
          n     <= n - 6'd1;
          state <= (n == 6'd1) ? S_IDLE : S_LDATA;
        end
        S_DREAD: begin
          ov_q  <= 1'b1;
          state <= S_DSEND;
        end
        S_DSEND: begin
          if (out_fire && sh_cnt == 2'd3) begin
            ov_q  <= 1'b0;
            idx   <= idx_inc;
            n     <= n - 6'd1;
            state <= (n == 6'd1) ? S_IDLE : S_DREAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef REG_LOADER_DUMP_EN
  assign out_valid = ov_q;
  assign out_byte  = ov_q ? sh_msb : 8'h00;
  assign ReadReg   = idx;
`else
  logic unused_dump;
  assign unused_dump = ^{sh_msb, sh_word[31:24]};
  assign out_valid   = 1'b0;
  assign out_byte    = 8'h00;
  assign ReadReg     = '0;
`endif

endmodule
